// File: rtl/axis_xdma_st_rr_arbiter.sv
// ============================================================================
// Module  : axis_xdma_st_rr_arbiter
// Purpose : Packet-level round-robin / fixed-priority AXI-Stream arbiter that
//           merges NUM_SRC generators onto one XDMA C2H stream port.
//           Optional macro AXIS_XDMA_ST_ARB_PKT_CNT_EN builds per-source
//           completed-packet counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_xdma_st_rr_arbiter #(
  parameter int NUM_SRC              = 4,
  parameter int C_M_AXIS_TDATA_WIDTH = 128
) (
  input  logic                                   M_AXIS_ACLK,
  input  logic                                   M_AXIS_ARESETN,
  input  logic [NUM_SRC-1:0]                     S_AXIS_TVALID,
  output logic [NUM_SRC-1:0]                     S_AXIS_TREADY,
  input  logic [NUM_SRC-1:0]                     S_AXIS_TLAST,
  input  logic [NUM_SRC*C_M_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [NUM_SRC*C_M_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  output logic                                   M_AXIS_TVALID,
  input  logic                                   M_AXIS_TREADY,
  output logic                                   M_AXIS_TLAST,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]        M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]      M_AXIS_TSTRB,
  input  logic [31:0]                            config_reg0,
  input  logic [31:0]                            config_reg1,
  output logic [2:0]                             grant_idx,
  output logic                                   busy,
  output logic [NUM_SRC*32-1:0]                  pkt_cnt
);

  localparam int DW = C_M_AXIS_TDATA_WIDTH;
  localparam int SW = C_M_AXIS_TDATA_WIDTH / 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [2:0]         grant, grant_nxt;
  logic [2:0]         last_grant, last_grant_nxt;
  logic [2:0]         hi_win, fp_win, rr_win;
  logic               hi_found;
  logic [NUM_SRC-1:0] req;
  logic               beat_done;
  logic               unused_cfg;

  assign req        = S_AXIS_TVALID & config_reg0[NUM_SRC-1:0];
  assign unused_cfg = ^{config_reg0[31:NUM_SRC], config_reg1[31:1]};

  // Round-robin = lowest requester above last_grant, else lowest overall
  // (which is also the fixed-priority winner).
  always_comb begin
    hi_win   = '0;
    hi_found = 1'b0;
    fp_win   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        fp_win = 3'(i);
        if (3'(i) > last_grant) begin
          hi_win   = 3'(i);
          hi_found = 1'b1;
        end
      end
    end
    rr_win = hi_found ? hi_win : fp_win;
  end

  assign beat_done = (state == BUSY) & M_AXIS_TVALID & M_AXIS_TREADY & M_AXIS_TLAST;

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_nxt = config_reg1[0] ? fp_win : rr_win;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (beat_done) begin
          last_grant_nxt = grant;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= 3'(NUM_SRC - 1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Purely combinational data path; handshake only passes through while BUSY.
  always_comb begin
    M_AXIS_TVALID = 1'b0;
    S_AXIS_TREADY = '0;
    M_AXIS_TDATA  = S_AXIS_TDATA[DW-1:0];
    M_AXIS_TSTRB  = S_AXIS_TSTRB[SW-1:0];
    M_AXIS_TLAST  = S_AXIS_TLAST[0];
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant == 3'(i)) begin
        M_AXIS_TDATA = S_AXIS_TDATA[i*DW +: DW];
        M_AXIS_TSTRB = S_AXIS_TSTRB[i*SW +: SW];
        M_AXIS_TLAST = S_AXIS_TLAST[i];
        if (state == BUSY) begin
          M_AXIS_TVALID    = S_AXIS_TVALID[i];
          S_AXIS_TREADY[i] = M_AXIS_TREADY;
        end
      end
    end
  end

  assign grant_idx = grant;
  assign busy      = (state == BUSY);

`ifdef AXIS_XDMA_ST_ARB_PKT_CNT_EN
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_pkt_cnt
    logic [31:0] cnt;
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
      if (!M_AXIS_ARESETN) begin
        cnt <= '0;
      end else if (beat_done && (grant == 3'(i))) begin
        cnt <= cnt + 32'd1;
      end
    end
    assign pkt_cnt[i*32 +: 32] = cnt;
  end
`else
  assign pkt_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_xdma_st_rr_arbiter.sv
// ============================================================================
// Module  : tb_axis_xdma_st_rr_arbiter
// Purpose : Directed self-checking bench for axis_xdma_st_rr_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_xdma_st_rr_arbiter;

  localparam int NS = 4;
  localparam int DW = 128;
  localparam int SW = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NS-1:0]  s_tvalid, s_tready, s_tlast;
  logic [NS*DW-1:0] s_tdata;
  logic [NS*SW-1:0] s_tstrb;
  logic           m_tvalid, m_tready, m_tlast;
  logic [DW-1:0]  m_tdata;
  logic [SW-1:0]  m_tstrb;
  logic [31:0]    cfg0, cfg1;
  logic [2:0]     grant_idx;
  logic           busy;
  logic [NS*32-1:0] pkt_cnt;

  always #5 clk = ~clk;

  axis_xdma_st_rr_arbiter #(.NUM_SRC(NS), .C_M_AXIS_TDATA_WIDTH(DW)) dut (
    .M_AXIS_ACLK   (clk),
    .M_AXIS_ARESETN(rst_n),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TREADY (s_tready),
    .S_AXIS_TLAST  (s_tlast),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TSTRB  (s_tstrb),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TREADY (m_tready),
    .M_AXIS_TLAST  (m_tlast),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TSTRB  (m_tstrb),
    .config_reg0   (cfg0),
    .config_reg1   (cfg1),
    .grant_idx     (grant_idx),
    .busy          (busy),
    .pkt_cnt       (pkt_cnt)
  );

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
    logic [2:0]    grant;
  } obs_t;

  typedef struct {
    int   cyc;
    int   src;
    int   pkt;
    int   beat;
    logic last;
  } exp_t;

  obs_t obs[$];
  exp_t expq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int s_len[NS], s_beat[NS], s_pkt[NS], s_left[NS];

  logic          smp_tvalid, smp_busy;
  logic [NS-1:0] smp_sready;
  logic [2:0]    smp_grant;

  function automatic logic [DW-1:0] mk_data(int src, int pkt, int beat);
    logic [31:0] w;
    w = {8'(src), 8'(pkt), 8'(beat), 8'h5A};
    return {4{w}};
  endfunction

  function automatic logic [SW-1:0] mk_strb(int src);
    return 16'((src + 1) * 16'h0111);
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic apply_src();
    for (int i = 0; i < NS; i++) begin
      s_tvalid[i]          = (s_left[i] > 0);
      s_tlast[i]           = (s_beat[i] == s_len[i] - 1);
      s_tdata[i*DW +: DW]  = mk_data(i, s_pkt[i], s_beat[i]);
      s_tstrb[i*SW +: SW]  = mk_strb(i);
    end
  endtask

  task automatic set_src(input int i, input int len, input int n);
    s_len[i]  = len;
    s_beat[i] = 0;
    s_pkt[i]  = 0;
    s_left[i] = n;
  endtask

  task automatic clear_src();
    for (int i = 0; i < NS; i++) set_src(i, 1, 0);
    apply_src();
  endtask

  // Sample on the falling edge, then advance the source models after the rising edge.
  task automatic tick();
    logic [NS-1:0] hs;
    @(negedge clk);
    smp_tvalid = m_tvalid;
    smp_busy   = busy;
    smp_sready = s_tready;
    smp_grant  = grant_idx;
    hs         = s_tvalid & s_tready;
    if (m_tvalid && m_tready)
      obs.push_back('{cyc, m_tdata, m_tstrb, m_tlast, grant_idx});
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (hs[i]) begin
        if (s_beat[i] == s_len[i] - 1) begin
          s_beat[i] = 0;
          s_pkt[i]++;
          s_left[i]--;
        end else begin
          s_beat[i]++;
        end
      end
    end
    apply_src();
    cyc++;
  endtask

  task automatic exp_pkt(input int c, input int src, input int pkt, input int len);
    for (int b = 0; b < len; b++)
      expq.push_back('{c + b, src, pkt, b, (b == len - 1)});
  endtask

  task automatic check_obs(input string tag);
    int n;
    check($sformatf("%s.nbeats", tag), obs.size(), expq.size());
    n = (obs.size() < expq.size()) ? obs.size() : expq.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.b%0d.cyc", tag, i),   obs[i].cyc,   expq[i].cyc);
      check($sformatf("%s.b%0d.grant", tag, i), obs[i].grant, expq[i].src);
      check($sformatf("%s.b%0d.data", tag, i),  obs[i].data,
            mk_data(expq[i].src, expq[i].pkt, expq[i].beat));
      check($sformatf("%s.b%0d.strb", tag, i),  obs[i].strb,  mk_strb(expq[i].src));
      check($sformatf("%s.b%0d.last", tag, i),  obs[i].last,  expq[i].last);
    end
    obs.delete();
    expq.delete();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    cfg0     = '0;
    cfg1     = '0;
    m_tready = 1'b1;
    clear_src();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
`ifdef AXIS_XDMA_ST_ARB_PKT_CNT_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  initial begin
    int c0;
    int r0;

    // Round-robin over four continuous 4-beat sources
    do_reset();
    check("rst.busy",   smp_busy,   1'b0);
    check("rst.grant",  smp_grant,  3'd0);
    check("rst.mvalid", smp_tvalid, 1'b0);
    check("rst.sready", smp_sready, 4'b0000);
    check("rst.pktcnt", pkt_cnt,    128'd0);
    cfg0 = 32'hF;
    cfg1 = 32'h0;
    for (int i = 0; i < NS; i++) set_src(i, 4, 100);
    apply_src();
    c0 = cyc;
    exp_pkt(c0 + 1,  0, 0, 4);
    exp_pkt(c0 + 6,  1, 0, 4);
    exp_pkt(c0 + 11, 2, 0, 4);
    exp_pkt(c0 + 16, 3, 0, 4);
    exp_pkt(c0 + 21, 0, 1, 4);
    repeat (25) tick();
    clear_src();
    check_obs("rr");
    check("rr.cnt0", pkt_cnt[0  +: 32], cnt_exp(2));
    check("rr.cnt3", pkt_cnt[96 +: 32], cnt_exp(1));

    // Fixed priority, then mask out source 0 mid-packet
    do_reset();
    cfg0 = 32'hF;
    cfg1 = 32'h1;
    for (int i = 0; i < NS; i++) set_src(i, 2, 100);
    apply_src();
    c0 = cyc;
    exp_pkt(c0 + 1,  0, 0, 2);
    exp_pkt(c0 + 4,  0, 1, 2);
    exp_pkt(c0 + 7,  0, 2, 2);
    exp_pkt(c0 + 10, 1, 0, 2);
    exp_pkt(c0 + 13, 1, 1, 2);
    repeat (7) tick();
    cfg0 = 32'hE;
    repeat (8) tick();
    clear_src();
    check_obs("fp");
    check("fp.cnt0", pkt_cnt[0  +: 32], cnt_exp(3));
    check("fp.cnt1", pkt_cnt[32 +: 32], cnt_exp(2));

    // Mask cleared during an 8-beat packet from source 2
    do_reset();
    cfg0 = 32'hF;
    set_src(2, 8, 2);
    apply_src();
    c0 = cyc;
    exp_pkt(c0 + 1, 2, 0, 8);
    repeat (3) tick();
    cfg0 = 32'h0;
    repeat (10) tick();
    check_obs("mask");
    check("mask.busy",   smp_busy,   1'b0);
    check("mask.mvalid", smp_tvalid, 1'b0);
    check("mask.grant",  smp_grant,  3'd2);
    check("mask.sready", smp_sready, 4'b0000);
    clear_src();

    // Downstream ready toggling during a source 1 packet
    do_reset();
    cfg0 = 32'hF;
    set_src(1, 4, 1);
    apply_src();
    c0 = cyc;
    for (int k = 0; k < 8; k++) begin
      m_tready = (k == 0) || (k % 2 == 1);
      tick();
      check($sformatf("bp.k%0d.sready", k), smp_sready, (k >= 1 && m_tready) ? 4'b0010 : 4'b0000);
      check($sformatf("bp.k%0d.mvalid", k), smp_tvalid, (k >= 1) ? 1'b1 : 1'b0);
    end
    m_tready = 1'b1;
    for (int b = 0; b < 4; b++)
      expq.push_back('{c0 + 1 + 2 * b, 1, 0, b, (b == 3)});
    check_obs("bp");

    // Back-to-back single-beat packets from source 3
    do_reset();
    cfg0 = 32'hF;
    set_src(3, 1, 10);
    apply_src();
    c0 = cyc;
    for (int k = 0; k < 10; k++) exp_pkt(c0 + 1 + 2 * k, 3, k, 1);
    repeat (20) tick();
    check_obs("single");
    check("single.cnt3", pkt_cnt[96 +: 32], cnt_exp(10));

    // Asynchronous reset in the middle of a packet
    do_reset();
    cfg0 = 32'hF;
    set_src(0, 3, 2);
    apply_src();
    c0 = cyc;
    exp_pkt(c0 + 1, 0, 0, 3);
    exp_pkt(c0 + 5, 0, 1, 3);
    void'(expq.pop_back());
    repeat (7) tick();
    check("arst.pre_mvalid", m_tvalid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.mvalid", m_tvalid, 1'b0);
    check("arst.busy",   busy,     1'b0);
    check("arst.grant",  grant_idx, 3'd0);
    check("arst.sready", s_tready, 4'b0000);
    check("arst.pktcnt", pkt_cnt,  128'd0);
    tick();
    tick();
    check_obs("arst_a");
    rst_n = 1'b1;
    clear_src();
    set_src(0, 2, 1);
    set_src(1, 2, 1);
    apply_src();
    r0 = cyc;
    exp_pkt(r0 + 1, 0, 0, 2);
    exp_pkt(r0 + 4, 1, 0, 2);
    repeat (6) tick();
    check_obs("arst_b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axis_xdma_st_rr_arbiter.md
Name: axis_xdma_st_rr_arbiter

Overview:
- Packet-level arbiter sharing one XDMA C2H AXI-Stream channel between NUM_SRC stream data generators.
- Grants one source at a time and holds the grant until that source's TLAST beat completes, so packets are never interleaved.
- Sits between the generator instances and the XDMA stream port. Mode and enable mask come from config registers.

Parameters:
- NUM_SRC, 4, number of slave stream inputs (2..8).
- C_M_AXIS_TDATA_WIDTH, 128, TDATA width of each stream in bits; TSTRB width is C_M_AXIS_TDATA_WIDTH/8.

Ports:
- M_AXIS_ACLK  in  1  single clock for all logic.
- M_AXIS_ARESETN  in  1  asynchronous active-low reset.
- S_AXIS_TVALID  in  NUM_SRC  per-source valid; bit i is source i.
- S_AXIS_TREADY  out  NUM_SRC  per-source ready.
- S_AXIS_TLAST  in  NUM_SRC  per-source last.
- S_AXIS_TDATA  in  NUM_SRC*C_M_AXIS_TDATA_WIDTH  flattened data; source i occupies slice i.
- S_AXIS_TSTRB  in  NUM_SRC*C_M_AXIS_TDATA_WIDTH/8  flattened strobes.
- M_AXIS_TVALID  out  1  merged output valid.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TLAST  out  1  merged last.
- M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  merged data.
- M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8  merged strobes.
- config_reg0  in  32  [NUM_SRC-1:0] source enable mask; remaining bits ignored.
- config_reg1  in  32  [0] priority mode: 0 = round-robin, 1 = fixed priority with source 0 highest.
- grant_idx  out  3  index of the currently granted source.
- busy  out  1  high while a grant is held.
- pkt_cnt  out  NUM_SRC*32  per-source completed-packet counters (see Optional Feature).

Behaviour:
- Reset (asynchronous, ARESETN low): state IDLE, grant_idx=0, busy=0, last_grant=NUM_SRC-1, all counters 0. Outputs while in reset: M_AXIS_TVALID=0, S_AXIS_TREADY=0. M_AXIS_TDATA, TSTRB and TLAST are don't-care, driven from the source 0 slice.
- State IDLE:
  - All S_AXIS_TREADY=0; M_AXIS_TVALID=0.
  - req = S_AXIS_TVALID & config_reg0[NUM_SRC-1:0].
  - If req is nonzero, pick the winner and register it in grant_idx, set busy=1 and go to BUSY on the next edge.
  - Round-robin winner: first set bit of req searching from last_grant+1 upward, wrapping modulo NUM_SRC.
  - Fixed-priority winner: lowest set bit of req.
- State BUSY (combinational mux on the registered grant):
  - M_AXIS_TVALID = S_AXIS_TVALID[g]; TDATA, TSTRB and TLAST come from slice g.
  - S_AXIS_TREADY[g] = M_AXIS_TREADY; all other readies are 0.
  - On an accepted beat (M_AXIS_TVALID & M_AXIS_TREADY & M_AXIS_TLAST): last_grant<=g, busy<=0, go to IDLE.
- Latency and throughput:
  - Zero-cycle data path: no registers in TDATA or TVALID.
  - One-cycle arbitration bubble before each packet.
  - Back-to-back packets from any sources: one idle cycle between TLAST and the next first beat.
- Boundary conditions:
  - Mask change mid-packet: current packet completes; the new mask applies at the next arbitration only.
  - Mode change mid-packet: same rule.
  - Granted source drops TVALID mid-packet: grant is held, M_AXIS_TVALID=0, and no other source is served.
  - Source drops TVALID while IDLE before the grant registers: grant is still taken. BUSY then waits for the source's next valid beat.
  - Single-beat packet (TLAST on the first beat): accepted in one BUSY cycle, then IDLE.
  - Downstream stall (TREADY=0): source ready is 0 and data is held upstream per AXI-S rules.
  - Simultaneous requests with last_grant=NUM_SRC-1 in round-robin mode: source 0 wins.
  - Reset mid-packet: grant dropped at once; the partial packet is not completed on the output.

Optional Feature:
- Macro: AXIS_XDMA_ST_ARB_PKT_CNT_EN.
- Defined:
  - pkt_cnt slice i is a 32-bit counter of source i's accepted TLAST beats.
  - Counters increment in the cycle the TLAST handshake occurs and wrap from 0xFFFFFFFF to 0.
  - Cleared by reset only.
- Not defined: pkt_cnt is tied to 0 and no counter registers are built.

Test Plan:
- Reset, mask=0xF, round-robin. All four sources each send a 4-beat packet continuously. Required output packet order is src0, src1, src2, src3, src0. Each packet is 4 beats with one bubble between packets. grant_idx follows 0,1,2,3.
- Fixed priority (config_reg1=1), all sources always valid. Only src0 is ever granted. Then mask=0xE: src1 is granted from the next arbitration.
- Mask cleared to 0 during beat 2 of a src2 8-beat packet. All 8 beats with TLAST appear on the output, then IDLE with no further grants.
- Downstream TREADY toggles 1,0,1,0 during a src1 packet. Output data equals the source data beat-for-beat. S_AXIS_TREADY[1] mirrors M_AXIS_TREADY and the other readies stay 0.
- Single-beat packets from src3 every cycle. Output is one beat every 2 cycles, each with TLAST=1. With the macro defined, pkt_cnt[3] is 10 after 10 packets.
- ARESETN pulsed low mid-packet. M_AXIS_TVALID is 0 within the same cycle, busy=0 and pkt_cnt=0. After release, arbitration restarts with src0 winning.
